// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester write-port arbiter for cpu_register
module regfile_write_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 5,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rr_mode,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  output logic          gnt_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_b,
  output logic [AW-1:0] addrw,
  output logic          writeen,
  output logic [DW-1:0] writeint,
  output logic          last_b
);

  // Saturation limit of the 4-bit wait counter.
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] addrw_q, addrw_d;
  logic [DW-1:0] writeint_q, writeint_d;
  logic          writeen_q, writeen_d;
  logic          last_b_q, last_b_d;
  logic          win_a, win_b;

  // Arbitration decision; at most one winner per cycle.
  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (req_a && req_b) begin
      if (rr_mode) begin
        win_b = !last_b_q;
      end else begin
        win_b = (wait_cnt_q == STARVE_LIM);
      end
      win_a = !win_b;
    end else begin
      win_a = req_a;
      win_b = req_b;
    end
  end

  // Visible grants are suppressed while reset is held; the internal winner
  // only feeds flops that are held in reset anyway.
  assign gnt_a = rst_n & win_a;
  assign gnt_b = rst_n & win_b;

  // Next state of the write port, recency flag and B wait counter.
  always_comb begin
    addrw_d    = addrw_q;
    writeint_d = writeint_q;
    writeen_d  = 1'b0;
    last_b_d   = last_b_q;
    wait_cnt_d = wait_cnt_q;
    if (win_a) begin
      addrw_d    = addr_a;
      writeint_d = data_a;
      writeen_d  = 1'b1;
      last_b_d   = 1'b0;
    end else if (win_b) begin
      addrw_d    = addr_b;
      writeint_d = data_b;
      writeen_d  = 1'b1;
      last_b_d   = 1'b1;
    end
    // Counts in both modes so a switch to fixed priority sees real history.
    if (!req_b || win_b) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < STARVE_LIM) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // State registers; reset discards any grant still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrw_q    <= '0;
      writeint_q <= '0;
      writeen_q  <= 1'b0;
      last_b_q   <= 1'b0;
      wait_cnt_q <= 4'd0;
    end else begin
      addrw_q    <= addrw_d;
      writeint_q <= writeint_d;
      writeen_q  <= writeen_d;
      last_b_q   <= last_b_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign addrw    = addrw_q;
  assign writeint = writeint_q;
  assign writeen  = writeen_q;
  assign last_b   = last_b_q;

endmodule
